// File: rtl/seq_detector_param.sv
// Serial pattern detector: flags when the last N accepted bits equal a loadable pattern,
// with overlapping/non-overlapping modes and a saturating match counter.
module seq_detector_param #(
  parameter int               N       = 8,
  parameter logic [N-1:0]     PATTERN = N'(8'b0111_1110),
  parameter int               COUNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               w,
  input  logic               w_valid,
  input  logic               overlap_en,
  input  logic               pattern_load,
  input  logic [N-1:0]       pattern_in,
  input  logic               clear_cnt,
  output logic               y,
  output logic [COUNT_W-1:0] match_count,
  output logic               cnt_sat
);

  localparam int               FW       = $clog2(N + 1);
  localparam logic [FW-1:0]    FILL_MAX = FW'(N);
  localparam logic [FW-1:0]    FILL_THR = FW'(N - 1);
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  logic [N-1:0]       pat_q, pat_d;
  logic [N-1:0]       hist_q, hist_d;
  logic [FW-1:0]      fill_q, fill_d;
  logic               y_q, y_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic               sat_q, sat_d;

  logic         accept;
  logic         hit;
  logic [N-1:0] shifted;

  // A load in the same cycle wins over the data strobe; that bit is dropped.
  assign accept  = w_valid & ~pattern_load;
  assign shifted = {hist_q[N-2:0], w};
  assign hit     = accept && (fill_q >= FILL_THR) && (shifted == pat_q);

  always_comb begin
    pat_d  = pat_q;
    hist_d = hist_q;
    fill_d = fill_q;
    y_d    = hit;
    if (pattern_load) begin
      pat_d  = pattern_in;
      hist_d = '0;
      fill_d = '0;
    end else if (accept) begin
      if (hit && !overlap_en) begin
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = shifted;
        fill_d = (fill_q == FILL_MAX) ? FILL_MAX : fill_q + 1'b1;
      end
    end
  end

  // Clear beats a same-cycle increment; the y pulse is unaffected.
  always_comb begin
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (clear_cnt) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (hit && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_MAX - 1'b1) sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat_q  <= PATTERN;
      hist_q <= '0;
      fill_q <= '0;
      y_q    <= 1'b0;
      cnt_q  <= '0;
      sat_q  <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      y_q    <= y_d;
      cnt_q  <= cnt_d;
      sat_q  <= sat_d;
    end
  end

  assign y           = y_q;
  assign match_count = cnt_q;
  assign cnt_sat     = sat_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param (N=8, COUNT_W=2): stimulus queues the expected
// y/count/sat for every driven cycle, a monitor checks each one after the clock edge.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       w, w_valid, overlap_en, pattern_load, clear_cnt;
  logic [7:0] pattern_in;
  logic       y;
  logic [1:0] match_count;
  logic       cnt_sat;

  typedef struct {
    logic       y;
    logic [1:0] cnt;
    logic       sat;
    string      nm;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   vecs = 0;
  int   miscompares = 0;
  logic [1:0] mcnt = 2'd0;
  logic       msat = 1'b0;

  seq_detector_param #(.N(8), .PATTERN(8'b0111_1110), .COUNT_W(2)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .w            (w),
    .w_valid      (w_valid),
    .overlap_en   (overlap_en),
    .pattern_load (pattern_load),
    .pattern_in   (pattern_in),
    .clear_cnt    (clear_cnt),
    .y            (y),
    .match_count  (match_count),
    .cnt_sat      (cnt_sat)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      vecs++;
      if (y !== e.y || match_count !== e.cnt || cnt_sat !== e.sat) begin
        miscompares++;
        $display("FAIL %s: got y=%b cnt=%0d sat=%b, want y=%b cnt=%0d sat=%b",
                 e.nm, y, match_count, cnt_sat, e.y, e.cnt, e.sat);
      end
    end
  end

  // ey is the hand-derived match outcome for this cycle; count/sat follow from it.
  task automatic drive(input logic v, input logic wb, input logic ld, input logic [7:0] pi,
                       input logic clr, input logic ovl, input logic ey, input string nm);
    @(negedge clk);
    w_valid = v; w = wb; pattern_load = ld; pattern_in = pi;
    clear_cnt = clr; overlap_en = ovl;
    if (clr) begin
      mcnt = 2'd0;
      msat = 1'b0;
    end else if (ey && mcnt != 2'd3) begin
      mcnt = mcnt + 2'd1;
    end
    if (mcnt == 2'd3) msat = 1'b1;
    q.push_back('{ey, mcnt, msat, nm});
  endtask

  // Accept n bits of seq MSB first; ym marks (MSB-aligned) which bits complete a match.
  task automatic bits(input logic [31:0] seq, input int n, input logic [31:0] ym,
                      input logic ovl, input string nm);
    for (int i = 0; i < n; i++)
      drive(1'b1, seq[n-1-i], 1'b0, 8'h00, 1'b0, ovl, ym[n-1-i], nm);
  endtask

  initial begin
    reset = 1'b0; w = 1'b0; w_valid = 1'b0; overlap_en = 1'b1;
    pattern_load = 1'b0; pattern_in = 8'h00; clear_cnt = 1'b0;
    q.push_back('{1'b0, 2'd0, 1'b0, "reset"});
    @(negedge clk);
    reset = 1'b1;

    bits(32'h00, 8, 32'h00, 1'b1, "t1_zeros");
    bits(32'h7E, 8, 32'h01, 1'b1, "t1_flag");

    bits(32'h7F, 8, 32'h00, 1'b1, "t2_ones");
    bits(32'h00, 1, 32'h00, 1'b1, "t2_tail");

    // Load 10101010 with a clear; the bit strobed in the load cycle is discarded.
    drive(1'b1, 1'b1, 1'b1, 8'hAA, 1'b1, 1'b1, 1'b0, "t3_load");
    bits(32'h2AA, 10, 32'b00_0000_0101, 1'b1, "t3_ovl");
    drive(1'b1, 1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, "t3_reload");
    bits(32'h2AA, 10, 32'b00_0000_0100, 1'b0, "t3_novl");

    drive(1'b0, 1'b0, 1'b1, 8'h7E, 1'b1, 1'b1, 1'b0, "t4_load");
    bits(32'b011, 3, 32'h0, 1'b1, "t4_head");
    for (int g = 0; g < 3; g++)
      drive(1'b0, 1'($urandom_range(1, 0)), 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, "t4_gap");
    bits(32'b11110, 5, 32'b00001, 1'b1, "t4_tail");

    bits(32'b0111, 4, 32'h0, 1'b1, "t5_head");
    @(negedge clk);
    reset = 1'b0; w_valid = 1'b0; pattern_load = 1'b0; clear_cnt = 1'b0;
    mcnt = 2'd0; msat = 1'b0;
    q.push_back('{1'b0, 2'd0, 1'b0, "t5_reset"});
    @(negedge clk);
    reset = 1'b1;
    bits(32'b1110, 4, 32'h0, 1'b1, "t5_post");
    bits(32'h7E, 8, 32'h01, 1'b1, "t5_flag");

    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, "t6_clr");
    for (int k = 0; k < 4; k++)
      bits(32'b111_1110, 7, 32'b000_0001, 1'b1, "t6_sat");
    bits(32'b11_1111, 6, 32'h0, 1'b1, "t6_head");
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, "t6_clr_hit");
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, "t6_idle");

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
